// File: rtl/pmp_csr.sv
// pmp_csr: PMP configuration/address CSR file with lock, TOR-lock and WARL legalisation.
module pmp_csr #(
  parameter int pmp_regions = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       csr_valid,
  input  logic [11:0]                csr_addr,
  input  logic [1:0]                 csr_op,
  input  logic [31:0]                csr_wdata,
  input  logic [1:0]                 priv_mode,
  output logic                       csr_rvalid,
  output logic [31:0]                csr_rdata,
  output logic                       csr_err,
  output logic                       pmp_update,
  output logic [8*pmp_regions-1:0]   pmpcfg_o,
  output logic [32*pmp_regions-1:0]  pmpaddr_o
);
  logic [15:0][7:0] cfg_q, cfg_d;
  logic [15:0][31:0] addr_q, addr_d;
  logic rvalid_q, rvalid_d, err_q, err_d, update_q, update_d;
  logic [31:0] rdata_q, rdata_d, old_val, new_val;
  logic is_cfg, is_addr, bad, wr;
  logic [15:0] addr_lock;
  logic [3:0] e;
  logic [7:0] b;
  always_comb begin
    is_cfg = csr_addr[11:2] == 10'h0E8;
    is_addr = csr_addr[11:4] == 8'h3B;
    bad = !(is_cfg || is_addr) || priv_mode != 2'b11;
    old_val = is_cfg ? cfg_q[{csr_addr[1:0], 2'b00} +: 4] : addr_q[csr_addr[3:0]];
    new_val = csr_op == 2'b01 ? csr_wdata : csr_op == 2'b10 ? old_val | csr_wdata : old_val & ~csr_wdata;
    wr = csr_valid && !bad && csr_op != 2'b00;
    cfg_d = cfg_q;
    addr_d = addr_q;
    e = '0;
    b = '0;
    // R=0,W=1 is reserved, so such a byte keeps its previous contents
    for (int j = 0; j < 4; j++) begin
      e = {csr_addr[1:0], 2'(j)};
      b = new_val[8*j +: 8] & 8'h9F;
      if (wr && is_cfg && int'(e) < pmp_regions && !cfg_q[e][7] && !(b[1] && !b[0])) cfg_d[e] = b;
    end
    for (int n = 0; n < 16; n++)
      addr_lock[n] = cfg_q[n][7] || (n + 1 < pmp_regions && cfg_q[(n+1)%16][7] && cfg_q[(n+1)%16][4:3] == 2'b01);
    if (wr && is_addr && int'(csr_addr[3:0]) < pmp_regions && !addr_lock[csr_addr[3:0]])
      addr_d[csr_addr[3:0]] = new_val;
    rvalid_d = csr_valid;
    err_d = csr_valid && bad;
    rdata_d = csr_valid && !bad ? old_val : '0;
    update_d = cfg_d != cfg_q || addr_d != addr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q <= '0;
      addr_q <= '0;
      rvalid_q <= 1'b0;
      err_q <= 1'b0;
      update_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      addr_q <= addr_d;
      rvalid_q <= rvalid_d;
      err_q <= err_d;
      update_q <= update_d;
      rdata_q <= rdata_d;
    end
  end
  assign csr_rvalid = rvalid_q;
  assign csr_rdata = rdata_q;
  assign csr_err = err_q;
  assign pmp_update = update_q;
  assign pmpcfg_o = cfg_q[pmp_regions-1:0];
  assign pmpaddr_o = addr_q[pmp_regions-1:0];
endmodule

// File: tb/tb_pmp_csr.sv
// tb_pmp_csr: directed and randomized checks of pmp_csr against a byte/word array reference model.
module tb_pmp_csr;
  localparam int R = 16;
  logic clk = 1'b0;
  logic rst, csr_valid, csr_rvalid, csr_err, pmp_update;
  logic [11:0] csr_addr;
  logic [1:0] csr_op, priv_mode;
  logic [31:0] csr_wdata, csr_rdata, last_rdata;
  logic [8*R-1:0] pmpcfg_o;
  logic [32*R-1:0] pmpaddr_o;
  int compared = 0, mismatched = 0;
  int m_cfg[16];
  logic [31:0] m_addr[16];

  pmp_csr #(.pmp_regions(R)) dut (
    .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .priv_mode(priv_mode), .csr_rvalid(csr_rvalid), .csr_rdata(csr_rdata),
    .csr_err(csr_err), .pmp_update(pmp_update), .pmpcfg_o(pmpcfg_o), .pmpaddr_o(pmpaddr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) begin
      m_cfg[i] = 0;
      m_addr[i] = '0;
    end
  endfunction

  function automatic void model(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                                input logic [1:0] pr, output logic [31:0] rd, output logic er, output logic up);
    int ai, k, i, bb;
    logic [31:0] old, nv;
    logic lk;
    ai = int'(a);
    rd = '0;
    er = 1'b0;
    up = 1'b0;
    if (pr != 2'b11 || !((ai >= 'h3A0 && ai <= 'h3A3) || (ai >= 'h3B0 && ai <= 'h3BF))) begin
      er = 1'b1;
      return;
    end
    old = '0;
    if (ai <= 'h3A3) begin
      k = ai - 'h3A0;
      for (int j = 0; j < 4; j++) old = old + (32'(m_cfg[4*k+j]) << (8*j));
    end else old = m_addr[ai - 'h3B0];
    rd = old;
    if (op == 2'd0) return;
    nv = op == 2'd1 ? wd : op == 2'd2 ? (old | wd) : (old & ~wd);
    if (ai <= 'h3A3) begin
      k = ai - 'h3A0;
      for (int j = 0; j < 4; j++) begin
        bb = int'((nv >> (8*j)) & 32'h9F);
        if (4*k+j < R && m_cfg[4*k+j] < 128 && (bb % 4) != 2 && bb != m_cfg[4*k+j]) begin
          m_cfg[4*k+j] = bb;
          up = 1'b1;
        end
      end
    end else begin
      i = ai - 'h3B0;
      lk = m_cfg[i] >= 128;
      if (i < 15 && i + 1 < R) lk = lk || (m_cfg[i+1] >= 128 && ((m_cfg[i+1] / 8) % 4) == 1);
      if (!lk && i < R && m_addr[i] != nv) begin
        m_addr[i] = nv;
        up = 1'b1;
      end
    end
  endfunction

  task automatic check_arrays(input string tag);
    logic [8*R-1:0] ec;
    logic [32*R-1:0] ea;
    for (int i = 0; i < R; i++) begin
      ec[8*i +: 8] = 8'(m_cfg[i]);
      ea[32*i +: 32] = m_addr[i];
    end
    chk({tag, ".pmpcfg_o"}, pmpcfg_o, ec);
    chk({tag, ".pmpaddr_o"}, pmpaddr_o, ea);
  endtask

  task automatic acc(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd, input logic [1:0] pr);
    logic [31:0] rd;
    logic er, up;
    string tag;
    tag = $sformatf("acc@%h/op%0d", a, op);
    model(a, op, wd, pr, rd, er, up);
    csr_valid = 1'b1;
    csr_addr = a;
    csr_op = op;
    csr_wdata = wd;
    priv_mode = pr;
    @(negedge clk);
    csr_valid = 1'b0;
    chk({tag, ".rvalid"}, csr_rvalid, 1'b1);
    chk({tag, ".rdata"}, csr_rdata, rd);
    chk({tag, ".err"}, csr_err, er);
    chk({tag, ".update"}, pmp_update, up);
    check_arrays(tag);
    last_rdata = csr_rdata;
  endtask

  task automatic idle();
    csr_valid = 1'b0;
    @(negedge clk);
    chk("idle.rvalid", csr_rvalid, 1'b0);
    chk("idle.update", pmp_update, 1'b0);
    check_arrays("idle");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    csr_valid = 1'b1;
    csr_addr = 12'h3B0;
    csr_op = 2'd1;
    csr_wdata = '1;
    priv_mode = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    csr_valid = 1'b0;
    model_clear();
    @(negedge clk);
    chk("reset.rvalid", csr_rvalid, 1'b0);
    chk("reset.err", csr_err, 1'b0);
    chk("reset.update", pmp_update, 1'b0);
    chk("reset.rdata", csr_rdata, 32'h0);
    check_arrays("reset");
  endtask

  initial begin
    logic [11:0] a;
    logic [31:0] wd;
    rst = 1'b1;
    csr_valid = 1'b0;
    csr_addr = '0;
    csr_op = '0;
    csr_wdata = '0;
    priv_mode = 2'b11;
    last_rdata = '0;
    model_clear();
    @(negedge clk);
    do_reset();
    acc(12'h3A0, 2'd0, 32'h0, 2'b11);
    acc(12'h3B5, 2'd0, 32'h0, 2'b11);
    acc(12'h3A0, 2'd1, 32'h0000_0F0B, 2'b11);
    chk("cfg0_wr_update", pmp_update, 1'b1);
    acc(12'h3A0, 2'd0, 32'h0, 2'b11);
    chk("cfg0_readback", last_rdata, 32'h0000_0F0B);
    chk("cfg0_read_no_update", pmp_update, 1'b0);
    acc(12'h3A0, 2'd1, 32'h0000_0F02, 2'b11);
    chk("warl_rw_reject_update", pmp_update, 1'b0);
    chk("warl_rw_reject_byte0", pmpcfg_o[7:0], 8'h0B);
    acc(12'h3A0, 2'd1, 32'h0000_0F8F, 2'b11);
    acc(12'h3A0, 2'd1, 32'h0, 2'b11);
    chk("locked_byte0", pmpcfg_o[15:0], 16'h008F);
    acc(12'h3B1, 2'd1, 32'h55, 2'b11);
    acc(12'h3A0, 2'd1, 32'h0000_8800, 2'b11);
    chk("cfg1_tor_lock", pmpcfg_o[15:0], 16'h888F);
    acc(12'h3B0, 2'd1, 32'h1234, 2'b11);
    chk("addr0_locked", pmpaddr_o[31:0], 32'h0);
    chk("addr0_locked_update", pmp_update, 1'b0);
    acc(12'h3B1, 2'd1, 32'h77, 2'b11);
    chk("addr1_locked", pmpaddr_o[63:32], 32'h55);
    acc(12'h3B2, 2'd1, 32'h1234, 2'b11);
    chk("addr2_accepted", pmpaddr_o[95:64], 32'h1234);
    acc(12'h3B3, 2'd2, 32'hF0, 2'b11);
    chk("set_old", last_rdata, 32'h0);
    acc(12'h3B3, 2'd3, 32'h30, 2'b11);
    chk("clear_old", last_rdata, 32'hF0);
    acc(12'h3B3, 2'd0, 32'h0, 2'b11);
    chk("clear_result", last_rdata, 32'hC0);
    acc(12'h3B4, 2'd1, 32'hABCD, 2'b00);
    chk("umode_err", csr_err, 1'b1);
    acc(12'h3C0, 2'd0, 32'h0, 2'b11);
    chk("badaddr_err", csr_err, 1'b1);
    acc(12'h3A4, 2'd1, 32'hFFFF_FFFF, 2'b11);
    idle();
    for (int it = 0; it < 300; it++) begin
      if (it % 60 == 0) do_reset();
      case ($urandom_range(0, 9))
        0: a = 12'($urandom);
        1, 2, 3: a = 12'h3A0 + 12'($urandom_range(0, 3));
        default: a = 12'h3B0 + 12'($urandom_range(0, 15));
      endcase
      wd = $urandom;
      if ($urandom_range(0, 7) != 0) wd = wd & 32'h7F7F_7F7F;
      acc(a, 2'($urandom), wd, $urandom_range(0, 7) == 0 ? 2'($urandom) : 2'b11);
      if ($urandom_range(0, 4) == 0) idle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
